// File: rtl/ifq_pkg.sv
// Shared constants, state codes and sizing helper for the instruction-fetch queue.
package ifq_pkg;

   localparam logic [31:0] NOP     = 32'h0000_0013;
   localparam logic [31:0] BOOT_PC = 32'h0000_0000;

   typedef logic [1:0] ifq_state_t;

   localparam ifq_state_t FETCH   = 2'd0;
   localparam ifq_state_t WAIT    = 2'd1;
   localparam ifq_state_t DISCARD = 2'd2;

   function automatic int lvl_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/ifq_fifo.sv
// DEPTH-entry synchronous FIFO of {inst, pc}; flush empties it and wins over push/pop.
module ifq_fifo
   import ifq_pkg::*;
#(
   parameter int             W       = 64,
   parameter int             DEPTH   = 4,
   parameter logic [W-1:0]   RST_VAL = '0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      flush,
   input  logic                      push,
   input  logic [W-1:0]              din,
   input  logic                      pop,
   output logic [W-1:0]              dout,
   output logic                      full,
   output logic                      empty,
   output logic [lvl_w(DEPTH)-1:0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = lvl_w(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (level == LW'(DEPTH));
   assign empty   = (level == '0);
   assign do_pop  = pop & ~empty;
   // A full queue still accepts a push when the head leaves in the same cycle.
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= RST_VAL;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         level <= level + LW'(do_push) - LW'(do_pop);
      end
   end

endmodule

// File: rtl/ifetch_queue.sv
// Sequential instruction fetch with a prefetch queue, redirect flush and stale-response discard.
// Build option IFQ_BYPASS_EN: an empty queue forwards a returning response straight to decode.
module ifetch_queue
   import ifq_pkg::*;
#(
   parameter int               XLEN    = 32,
   parameter int               IADDR_W = 16,
   parameter int               DEPTH   = 4,
   parameter logic [XLEN-1:0]  BOOT    = XLEN'(BOOT_PC)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   output logic [IADDR_W-1:0]         imem_addr,
   output logic                       imem_oe,
   input  logic [31:0]                imem_rdata,
   input  logic                       imem_ready,
   input  logic                       redirect,
   input  logic [XLEN-1:0]            redirect_pc,
   output logic                       id_valid,
   output logic [31:0]                id_inst,
   output logic [XLEN-1:0]            id_pc,
   input  logic                       id_ready,
   output logic [lvl_w(DEPTH)-1:0]    level,
   output ifq_state_t                 fsm_state
);

   // Handshakes: the head transfers when id_valid && id_ready at a rising edge; an imem
   // request stays presented (imem_oe, imem_addr stable) until the cycle imem_ready=1.

   localparam int LW = lvl_w(DEPTH);
   localparam int OW = LW + 1;
   localparam int EW = 32 + XLEN;

   logic [XLEN-1:0] fpc;
   logic [XLEN-1:0] req_pc;
   logic            outstanding;
   logic            run;
   ifq_state_t      state;
   ifq_state_t      state_nxt;

   logic            resp;
   logic            hold;
   logic            resp_ok;
   logic            issue;
   logic            byp_take;
   logic            fifo_push;
   logic            fifo_pop;
   logic            fifo_full;
   logic            fifo_empty;
   logic [LW-1:0]   fifo_level;
   logic [EW-1:0]   head;
   logic [OW-1:0]   occ;

   assign resp     = outstanding & imem_ready;
   assign hold     = outstanding & ~imem_ready;
   // The response owed to a pre-redirect request is never queued.
   assign resp_ok  = resp & (state != DISCARD) & ~redirect;
   assign fifo_pop = ~fifo_empty & id_ready & ~redirect;

`ifdef IFQ_BYPASS_EN
   logic byp;
   assign byp      = resp_ok & fifo_empty;
   assign byp_take = byp & id_ready;
   assign id_valid = ~fifo_empty | byp;
   assign id_inst  = byp ? imem_rdata : head[XLEN +: 32];
   assign id_pc    = byp ? req_pc : head[XLEN-1:0];
`else
   assign byp_take = 1'b0;
   assign id_valid = ~fifo_empty;
   assign id_inst  = head[XLEN +: 32];
   assign id_pc    = head[XLEN-1:0];
`endif

   assign fifo_push = resp_ok & ~byp_take;
   assign occ       = {1'b0, fifo_level} + OW'(fifo_push) - OW'(fifo_pop);
   // Credit: a new request must have a guaranteed slot once its response lands.
   assign issue     = run & ~redirect & ~hold & (occ < OW'(DEPTH)) & ~(fifo_full & ~fifo_pop);
   assign imem_oe   = hold | issue;
   assign imem_addr = hold ? req_pc[IADDR_W-1:0] : fpc[IADDR_W-1:0];
   assign level     = fifo_level;
   assign fsm_state = state;

   always_comb begin
      state_nxt = FETCH;
      if (redirect)                    state_nxt = hold ? DISCARD : FETCH;
      else if (state == DISCARD && hold) state_nxt = DISCARD;
      else if (hold)                   state_nxt = WAIT;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run         <= 1'b0;
         fpc         <= BOOT;
         req_pc      <= BOOT;
         outstanding <= 1'b0;
         state       <= FETCH;
      end else begin
         run   <= 1'b1;
         state <= state_nxt;
         if (redirect) begin
            fpc         <= redirect_pc & ~XLEN'(1);
            outstanding <= hold;
         end else if (issue) begin
            req_pc      <= fpc;
            fpc         <= fpc + XLEN'(4);
            outstanding <= 1'b1;
         end else if (resp) begin
            outstanding <= 1'b0;
         end
      end
   end

   ifq_fifo #(
      .W       (EW),
      .DEPTH   (DEPTH),
      .RST_VAL ({NOP, BOOT})
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (redirect),
      .push  (fifo_push),
      .din   ({imem_rdata, req_pc}),
      .pop   (fifo_pop),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue with a one-outstanding instruction memory model.
module tb_ifetch_queue;

   localparam logic [1:0]  S_FETCH = 2'd0;
   localparam logic [1:0]  S_WAIT  = 2'd1;
   localparam logic [1:0]  S_DISC  = 2'd2;
   localparam logic [31:0] NOP_I   = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] imem_addr;
   logic        imem_oe;
   logic [31:0] imem_rdata;
   logic        imem_ready = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        id_valid;
   logic [31:0] id_inst;
   logic [31:0] id_pc;
   logic        id_ready = 1'b0;
   logic [2:0]  level;
   logic [1:0]  fsm_state;

   int checks = 0;
   int errors = 0;

   logic [15:0] addr_q[$];
   logic [31:0] got_pc_q[$];
   logic [31:0] got_inst_q[$];

   logic        mem_pend;
   logic [15:0] mem_addr;

   ifetch_queue dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_addr   (imem_addr),
      .imem_oe     (imem_oe),
      .imem_rdata  (imem_rdata),
      .imem_ready  (imem_ready),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .id_valid    (id_valid),
      .id_inst     (id_inst),
      .id_pc       (id_pc),
      .id_ready    (id_ready),
      .level       (level),
      .fsm_state   (fsm_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] inst_of(input logic [15:0] a);
      return {16'hC0DE, a};
   endfunction

   // memory: latches the address of each accepted request, answers when imem_ready=1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_pend <= 1'b0;
         mem_addr <= '0;
      end else if (imem_oe && (!mem_pend || imem_ready)) begin
         mem_pend <= 1'b1;
         mem_addr <= imem_addr;
      end else if (imem_ready) begin
         mem_pend <= 1'b0;
      end
   end
   assign imem_rdata = inst_of(mem_addr);

   // driver tasks
   task automatic step(input logic rdy, input logic idr, input logic rd, input logic [31:0] rpc);
      @(negedge clk);
      imem_ready  = rdy;
      id_ready    = idr;
      redirect    = rd;
      redirect_pc = rpc;
      #1;
      if (imem_oe && (!mem_pend || imem_ready)) addr_q.push_back(imem_addr);
      if (id_valid && id_ready) begin
         got_pc_q.push_back(id_pc);
         got_inst_q.push_back(id_inst);
      end
   endtask

   task automatic clear_logs();
      addr_q.delete();
      got_pc_q.delete();
      got_inst_q.delete();
   endtask

   task automatic do_reset();
      imem_ready  = 1'b0;
      id_ready    = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      rst_n       = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      clear_logs();
   endtask

   // tests
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (imem_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %0b expected 0", imem_oe); end
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", id_valid); end
      checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
      checks++; if (id_inst !== NOP_I) begin errors++; $display("FAIL reset_inst: got %h expected %h", id_inst, NOP_I); end
      checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", id_pc); end
      checks++; if (fsm_state !== S_FETCH) begin errors++; $display("FAIL reset_state: got %0d expected %0d", fsm_state, S_FETCH); end
   endtask

   task automatic test_boot();
      int  bubbles;
      bit  seen;
      bubbles = 0;
      seen    = 1'b0;
      do_reset();
      for (int i = 0; i < 14; i++) begin
         step(1'b1, 1'b1, 1'b0, '0);
         if (seen && !id_valid) bubbles++;
         if (id_valid) seen = 1'b1;
      end
      checks++; if (addr_q.size() < 10) begin errors++; $display("FAIL boot_addr_count: got %0d expected >=10", addr_q.size()); end
      for (int i = 0; i < 10 && i < addr_q.size(); i++) begin
         checks++; if (addr_q[i] !== 16'(4 * i)) begin errors++; $display("FAIL boot_addr[%0d]: got %h expected %h", i, addr_q[i], 16'(4 * i)); end
      end
      checks++; if (got_pc_q.size() < 8) begin errors++; $display("FAIL boot_pc_count: got %0d expected >=8", got_pc_q.size()); end
      for (int i = 0; i < 8 && i < got_pc_q.size(); i++) begin
         checks++; if (got_pc_q[i] !== 32'(4 * i)) begin errors++; $display("FAIL boot_pc[%0d]: got %h expected %h", i, got_pc_q[i], 32'(4 * i)); end
         checks++; if (got_inst_q[i] !== inst_of(16'(4 * i))) begin errors++; $display("FAIL boot_inst[%0d]: got %h expected %h", i, got_inst_q[i], inst_of(16'(4 * i))); end
      end
      checks++; if (bubbles != 0) begin errors++; $display("FAIL boot_bubbles: got %0d expected 0", bubbles); end
      checks++; if (level !== 3'd1) begin errors++; $display("FAIL boot_level: got %0d expected 1", level); end
   endtask

   task automatic test_backpressure();
      do_reset();
      repeat (10) step(1'b1, 1'b0, 1'b0, '0);
      checks++; if (level !== 3'd4) begin errors++; $display("FAIL bp_level: got %0d expected 4", level); end
      checks++; if (imem_oe !== 1'b0) begin errors++; $display("FAIL bp_oe: got %0b expected 0", imem_oe); end
      checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %0b expected 1", id_valid); end
      checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL bp_head_pc: got %h expected 0", id_pc); end
      checks++; if (addr_q.size() != 4) begin errors++; $display("FAIL bp_issued: got %0d expected 4", addr_q.size()); end
      clear_logs();
      repeat (16) step(1'b1, 1'b1, 1'b0, '0);
      checks++; if (got_pc_q.size() != 16) begin errors++; $display("FAIL bp_drain_count: got %0d expected 16", got_pc_q.size()); end
      for (int i = 0; i < 16 && i < got_pc_q.size(); i++) begin
         checks++; if (got_pc_q[i] !== 32'(4 * i)) begin errors++; $display("FAIL bp_pc[%0d]: got %h expected %h", i, got_pc_q[i], 32'(4 * i)); end
         checks++; if (got_inst_q[i] !== inst_of(16'(4 * i))) begin errors++; $display("FAIL bp_inst[%0d]: got %h expected %h", i, got_inst_q[i], inst_of(16'(4 * i))); end
      end
   endtask

   task automatic test_miss();
      bit found;
      found = 1'b0;
      do_reset();
      for (int i = 0; i < 20 && !found; i++) begin
         step(1'b1, 1'b1, 1'b0, '0);
         if (imem_oe && imem_addr == 16'h8) found = 1'b1;
      end
      checks++; if (!found) begin errors++; $display("FAIL miss_setup: address 0x8 got none expected issued"); end
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 1'b1, 1'b0, '0);
         checks++; if (imem_oe !== 1'b1) begin errors++; $display("FAIL miss_oe[%0d]: got %0b expected 1", k, imem_oe); end
         checks++; if (imem_addr !== 16'h8) begin errors++; $display("FAIL miss_addr[%0d]: got %h expected 0008", k, imem_addr); end
         if (k > 0) begin
            checks++; if (fsm_state !== S_WAIT) begin errors++; $display("FAIL miss_state[%0d]: got %0d expected %0d", k, fsm_state, S_WAIT); end
         end
      end
      repeat (8) step(1'b1, 1'b1, 1'b0, '0);
      checks++; if (got_pc_q.size() < 5) begin errors++; $display("FAIL miss_count: got %0d expected >=5", got_pc_q.size()); end
      for (int i = 0; i < 5 && i < got_pc_q.size(); i++) begin
         checks++; if (got_pc_q[i] !== 32'(4 * i)) begin errors++; $display("FAIL miss_pc[%0d]: got %h expected %h", i, got_pc_q[i], 32'(4 * i)); end
         checks++; if (got_inst_q[i] !== inst_of(16'(4 * i))) begin errors++; $display("FAIL miss_inst[%0d]: got %h expected %h", i, got_inst_q[i], inst_of(16'(4 * i))); end
      end
   endtask

   task automatic test_redirect_outstanding();
      bit found;
      found = 1'b0;
      do_reset();
      for (int i = 0; i < 20 && !found; i++) begin
         step(1'b1, 1'b1, 1'b0, '0);
         if (imem_oe && imem_addr == 16'h10) found = 1'b1;
      end
      checks++; if (!found) begin errors++; $display("FAIL rdo_setup: address 0x10 got none expected issued"); end
      step(1'b0, 1'b1, 1'b0, '0);
      checks++; if (imem_addr !== 16'h10) begin errors++; $display("FAIL rdo_hold_addr: got %h expected 0010", imem_addr); end
      step(1'b0, 1'b1, 1'b1, 32'h101);
      checks++; if (imem_oe !== 1'b1 || imem_addr !== 16'h10) begin errors++; $display("FAIL rdo_redir_hold: got oe=%0b addr=%h expected oe=1 addr=0010", imem_oe, imem_addr); end
      clear_logs();
      step(1'b0, 1'b1, 1'b0, '0);
      checks++; if (fsm_state !== S_DISC) begin errors++; $display("FAIL rdo_state: got %0d expected %0d", fsm_state, S_DISC); end
      checks++; if (level !== 3'd0) begin errors++; $display("FAIL rdo_level: got %0d expected 0", level); end
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rdo_valid: got %0b expected 0", id_valid); end
      checks++; if (imem_oe !== 1'b1 || imem_addr !== 16'h10) begin errors++; $display("FAIL rdo_disc_hold: got oe=%0b addr=%h expected oe=1 addr=0010", imem_oe, imem_addr); end
      step(1'b1, 1'b1, 1'b0, '0);
      checks++; if (imem_oe !== 1'b1 || imem_addr !== 16'h100) begin errors++; $display("FAIL rdo_target: got oe=%0b addr=%h expected oe=1 addr=0100", imem_oe, imem_addr); end
      repeat (6) step(1'b1, 1'b1, 1'b0, '0);
      checks++; if (got_pc_q.size() < 2) begin errors++; $display("FAIL rdo_count: got %0d expected >=2", got_pc_q.size()); end
      if (got_pc_q.size() >= 2) begin
         checks++; if (got_pc_q[0] !== 32'h100) begin errors++; $display("FAIL rdo_first_pc: got %h expected 00000100", got_pc_q[0]); end
         checks++; if (got_inst_q[0] !== inst_of(16'h100)) begin errors++; $display("FAIL rdo_first_inst: got %h expected %h", got_inst_q[0], inst_of(16'h100)); end
         checks++; if (got_pc_q[1] !== 32'h104) begin errors++; $display("FAIL rdo_second_pc: got %h expected 00000104", got_pc_q[1]); end
      end
   endtask

   task automatic test_redirect_collision();
      do_reset();
      repeat (4) step(1'b1, 1'b0, 1'b0, '0);
      step(1'b1, 1'b1, 1'b1, 32'h200);
      checks++; if (level !== 3'd3) begin errors++; $display("FAIL col_pre_level: got %0d expected 3", level); end
      checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL col_pre_valid: got %0b expected 1", id_valid); end
      checks++; if (imem_oe !== 1'b0) begin errors++; $display("FAIL col_no_issue: got %0b expected 0", imem_oe); end
      clear_logs();
      step(1'b1, 1'b1, 1'b0, '0);
      checks++; if (level !== 3'd0) begin errors++; $display("FAIL col_level: got %0d expected 0", level); end
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL col_valid: got %0b expected 0", id_valid); end
      checks++; if (fsm_state !== S_FETCH) begin errors++; $display("FAIL col_state: got %0d expected %0d", fsm_state, S_FETCH); end
      checks++; if (imem_oe !== 1'b1 || imem_addr !== 16'h200) begin errors++; $display("FAIL col_target: got oe=%0b addr=%h expected oe=1 addr=0200", imem_oe, imem_addr); end
      repeat (5) step(1'b1, 1'b1, 1'b0, '0);
      checks++; if (got_pc_q.size() < 2) begin errors++; $display("FAIL col_count: got %0d expected >=2", got_pc_q.size()); end
      if (got_pc_q.size() >= 2) begin
         checks++; if (got_pc_q[0] !== 32'h200) begin errors++; $display("FAIL col_first_pc: got %h expected 00000200", got_pc_q[0]); end
         checks++; if (got_pc_q[1] !== 32'h204) begin errors++; $display("FAIL col_second_pc: got %h expected 00000204", got_pc_q[1]); end
      end
   endtask

   task automatic test_reset_mid_miss();
      do_reset();
      repeat (3) step(1'b1, 1'b0, 1'b0, '0);
      repeat (2) step(1'b0, 1'b0, 1'b0, '0);
      checks++; if (fsm_state !== S_WAIT) begin errors++; $display("FAIL rmm_pre_state: got %0d expected %0d", fsm_state, S_WAIT); end
      checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL rmm_pre_valid: got %0b expected 1", id_valid); end
      checks++; if (imem_oe !== 1'b1 || imem_addr !== 16'h8) begin errors++; $display("FAIL rmm_pre_req: got oe=%0b addr=%h expected oe=1 addr=0008", imem_oe, imem_addr); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (imem_oe !== 1'b0) begin errors++; $display("FAIL rmm_oe: got %0b expected 0", imem_oe); end
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rmm_valid: got %0b expected 0", id_valid); end
      checks++; if (level !== 3'd0) begin errors++; $display("FAIL rmm_level: got %0d expected 0", level); end
      checks++; if (fsm_state !== S_FETCH) begin errors++; $display("FAIL rmm_state: got %0d expected %0d", fsm_state, S_FETCH); end
      checks++; if (id_inst !== NOP_I) begin errors++; $display("FAIL rmm_inst: got %h expected %h", id_inst, NOP_I); end
      @(negedge clk);
      rst_n = 1'b1;
      clear_logs();
      repeat (7) step(1'b1, 1'b1, 1'b0, '0);
      checks++; if (addr_q.size() < 1) begin errors++; $display("FAIL rmm_refetch: got %0d requests expected >=1", addr_q.size()); end
      if (addr_q.size() >= 1) begin
         checks++; if (addr_q[0] !== 16'h0) begin errors++; $display("FAIL rmm_first_addr: got %h expected 0000", addr_q[0]); end
      end
      checks++; if (got_pc_q.size() < 1) begin errors++; $display("FAIL rmm_count: got %0d expected >=1", got_pc_q.size()); end
      if (got_pc_q.size() >= 1) begin
         checks++; if (got_pc_q[0] !== 32'h0) begin errors++; $display("FAIL rmm_first_pc: got %h expected 00000000", got_pc_q[0]); end
      end
   endtask

   initial begin
      test_reset();
      test_boot();
      test_backpressure();
      test_miss();
      test_redirect_outstanding();
      test_redirect_collision();
      test_reset_mid_miss();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
